// File: rtl/pulse_pacer_pkg.sv
// rtl/pulse_pacer_pkg.sv - shared types and helpers for the pulse pacer
package pulse_pacer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SPACE = 1'b1
  } pacer_state_t;

  // Smallest safe GAP when feeding a pulse synchronizer whose slow clock is
  // fast_ratio times slower: three slow periods plus two cycles of margin.
  function automatic int pacer_gap_min(input int fast_ratio);
    return 3 * fast_ratio + 2;
  endfunction

endpackage

// File: rtl/sat_updown_cnt.sv
// rtl/sat_updown_cnt.sv - saturating up/down counter with lost-increment flag
module sat_updown_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         sat_hit
);

  localparam logic [W-1:0] MAX = '1;

  // An increment is lost only when it is not cancelled by a decrement.
  assign sat_hit = inc && !dec && !clr && (count == MAX);

  // Count register: clamps at both ends instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !dec && (count != MAX)) begin
      count <= count + W'(1);
    end else if (dec && !inc && (count != '0)) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/pulse_pacer.sv
// rtl/pulse_pacer.sv - queues event pulses and re-emits them with minimum spacing
module pulse_pacer
  import pulse_pacer_pkg::*;
#(
  parameter int GAP   = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  input  logic             clear,
  output logic             out,
  output logic [CNT_W-1:0] pending,
  output logic             overflow,
  output logic             busy
);

  localparam int GW = (GAP > 2) ? $clog2(GAP - 1) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP - 2);

  pacer_state_t  state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          fire;
  logic          sat_hit;
  logic          inc;

  // Events arriving with clear are dropped along with the queue.
  assign inc = in && !clear;

  sat_updown_cnt #(.W(CNT_W)) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc     (inc),
    .dec     (fire),
    .clr     (clear),
    .count   (pending),
    .sat_hit (sat_hit)
  );

  // Next state: fire from IDLE when work is queued, then hold off GAP-1 cycles.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    fire    = 1'b0;
    case (state_q)
      IDLE: begin
        if ((pending != '0) && !clear) begin
          fire    = 1'b1;
          state_d = SPACE;
          gap_d   = GAP_LOAD;
        end
      end
      SPACE: begin
        if (gap_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and gap counter; clear leaves them alone so spacing survives a flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  // Registered pulse output and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      out      <= 1'b0;
      overflow <= 1'b0;
    end else begin
      out <= fire;
      if (clear) begin
        overflow <= 1'b0;
      end else if (sat_hit) begin
        overflow <= 1'b1;
      end
    end
  end

  assign busy = (pending != '0) || (state_q != IDLE) || out;

endmodule

// File: tb/tb_pulse_pacer.sv
// tb/tb_pulse_pacer.sv - scoreboard bench for pulse_pacer
module tb_pulse_pacer;
  import pulse_pacer_pkg::*;

  logic       clk = 1'b0;
  logic       reset, clear, in_a, in_b;
  logic       out_a, out_b, ovf_a, ovf_b, busy_a, busy_b;
  logic [3:0] pend_a;
  logic [1:0] pend_b;

  int cyc;
  int n_tests = 0;
  int n_fail  = 0;
  int qa[$];
  int qb[$];
  int max_p;

  always #5 clk = ~clk;

  pulse_pacer #(.GAP(8), .CNT_W(4)) ua (
    .clk(clk), .reset(reset), .in(in_a), .clear(clear),
    .out(out_a), .pending(pend_a), .overflow(ovf_a), .busy(busy_a)
  );

  pulse_pacer #(.GAP(8), .CNT_W(2)) ub (
    .clk(clk), .reset(reset), .in(in_b), .clear(clear),
    .out(out_b), .pending(pend_b), .overflow(ovf_b), .busy(busy_b)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance one cycle; every out pulse is matched against the expected queue.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (out_a) begin
      if (qa.size() == 0) check_eq("a_out_extra", cyc, -1);
      else check_eq("a_out_cycle", cyc, qa.pop_front());
    end
    if (out_b) begin
      if (qb.size() == 0) check_eq("b_out_extra", cyc, -1);
      else check_eq("b_out_cycle", cyc, qb.pop_front());
    end
  endtask

  task automatic start_scn();
    reset = 1'b1;
    clear = 1'b0;
    in_a  = 1'b0;
    in_b  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    cyc   = 0;
    qa.delete();
    qb.delete();
    check_eq("rst_pend_a", pend_a, 0);
    check_eq("rst_ovf_a", ovf_a, 0);
    check_eq("rst_busy_a", busy_a, 0);
    check_eq("rst_out_a", out_a, 0);
  endtask

  task automatic end_scn(input string tag);
    check_eq({tag, "_qa_left"}, qa.size(), 0);
    check_eq({tag, "_qb_left"}, qb.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Single event
    start_scn();
    qa.push_back(12);
    while (cyc < 30) begin
      in_a = (cyc == 10);
      if (cyc == 11) check_eq("single_pend11", pend_a, 1);
      if (cyc == 12) check_eq("single_busy12", busy_a, 1);
      if (cyc == 13) check_eq("single_pend13", pend_a, 0);
      if (cyc == 20) check_eq("single_busy20", busy_a, 0);
      tick();
    end
    end_scn("single");

    // Burst of five
    start_scn();
    qa.push_back(12); qa.push_back(20); qa.push_back(28);
    qa.push_back(36); qa.push_back(44);
    max_p = 0;
    while (cyc < 60) begin
      in_a = (cyc >= 10 && cyc <= 14);
      if (int'(pend_a) > max_p) max_p = pend_a;
      if (cyc == 13) check_eq("burst_pend13", pend_a, 2);
      if (cyc == 15) check_eq("burst_pend15", pend_a, 4);
      tick();
    end
    check_eq("burst_peak", max_p, 4);
    check_eq("burst_ovf", ovf_a, 0);
    end_scn("burst");

    // Saturation on the 2-bit counter
    start_scn();
    qb.push_back(2); qb.push_back(10); qb.push_back(18); qb.push_back(26);
    while (cyc < 40) begin
      in_b = (cyc <= 5);
      if (cyc == 3) check_eq("sat_pend3", pend_b, 2);
      if (cyc == 4) begin
        check_eq("sat_pend4", pend_b, 3);
        check_eq("sat_ovf4", ovf_b, 0);
      end
      if (cyc == 5) check_eq("sat_ovf5", ovf_b, 1);
      if (cyc == 6) check_eq("sat_pend6", pend_b, 3);
      tick();
    end
    check_eq("sat_ovf_sticky", ovf_b, 1);
    check_eq("sat_pend_end", pend_b, 0);
    end_scn("sat");

    // Simultaneous in and fire at full count
    start_scn();
    qb.push_back(2); qb.push_back(10); qb.push_back(18);
    qb.push_back(26); qb.push_back(34);
    while (cyc < 45) begin
      in_b = (cyc <= 3) || (cyc == 9);
      if (cyc == 9) check_eq("full_pend9", pend_b, 3);
      if (cyc == 10) begin
        check_eq("full_pend10", pend_b, 3);
        check_eq("full_ovf10", ovf_b, 0);
      end
      tick();
    end
    check_eq("full_ovf_end", ovf_b, 0);
    end_scn("full");

    // Clear mid-gap
    start_scn();
    qa.push_back(20); qa.push_back(28);
    qb.push_back(2); qb.push_back(10); qb.push_back(18);
    while (cyc < 50) begin
      in_a  = (cyc >= 18 && cyc <= 23);
      in_b  = (cyc <= 5);
      clear = (cyc == 22);
      if (cyc == 22) begin
        check_eq("clr_pend_a22", pend_a, 3);
        check_eq("clr_pend_b22", pend_b, 1);
        check_eq("clr_ovf_b22", ovf_b, 1);
      end
      if (cyc == 23) begin
        check_eq("clr_pend_a23", pend_a, 0);
        check_eq("clr_ovf_a23", ovf_a, 0);
        check_eq("clr_pend_b23", pend_b, 0);
        check_eq("clr_ovf_b23", ovf_b, 0);
      end
      if (cyc == 24) check_eq("clr_pend_a24", pend_a, 1);
      tick();
    end
    clear = 1'b0;
    end_scn("clear");

    // Reset mid-SPACE
    start_scn();
    qa.push_back(20); qa.push_back(32);
    while (cyc < 45) begin
      in_a  = (cyc >= 18 && cyc <= 20) || (cyc == 30);
      reset = (cyc == 25);
      if (cyc == 25) check_eq("rst_mid_pend25", pend_a, 2);
      if (cyc == 26) begin
        check_eq("rst_mid_out26", out_a, 0);
        check_eq("rst_mid_pend26", pend_a, 0);
        check_eq("rst_mid_ovf26", ovf_a, 0);
        check_eq("rst_mid_busy26", busy_a, 0);
      end
      tick();
    end
    end_scn("rst_mid");

    check_eq("gap_min_ratio2", pacer_gap_min(2), 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_pacer.md
# pulse_pacer

Rate-limiting stage upstream of the one-way pulse synchronizer in the JPEG/camera path. It accepts single-cycle event pulses that may arrive back-to-back or in bursts, and counts them as pending. It re-emits each one as an isolated single-cycle pulse, with a guaranteed minimum spacing, so the downstream toggle-based synchronizer never sees two events closer than it can resolve. Pulses are queued and never silently merged, except on counter saturation, which is flagged.

## Interface
- `GAP`, default 8: minimum cycles from one `out` rising edge to the next; legal range 2..256.
- `CNT_W`, default 4: width of the pending-event counter; capacity is 2^CNT_W−1 events.
- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high reset (single clock; polarity and synchronicity fixed).
- `in`  in  1  event pulse; each high cycle is one event.
- `clear`  in  1  synchronous flush of pending events and the overflow flag.
- `out`  out  1  paced single-cycle event pulse, registered.
- `pending`  out  CNT_W  events accepted but not yet emitted.
- `overflow`  out  1  sticky: an event was lost to saturation.
- `busy`  out  1  high when `pending`≠0, or state≠IDLE, or `out`=1.

## Operation
- States: IDLE and SPACE.
  - IDLE: `fire` = (`pending`≠0).
  - On `fire`: go to SPACE, load `gap_cnt` ← GAP−2.
  - SPACE: decrement `gap_cnt` each cycle.
  - SPACE with `gap_cnt`=0: go to IDLE.
- `out` ← `fire`, registered. Always exactly one cycle wide.
- Pending counter update, with `inc` = `in`, `dec` = `fire`:
  - `inc` and not `dec`: +1. If already at max, hold max and set `overflow`.
  - `dec` and not `inc`: −1.
  - Both or neither: unchanged.
- Simultaneous `in` and `fire` at full count is not an overflow.
- `clear`:
  - `pending` ← 0, `overflow` ← 0.
  - Any `in` in the same cycle is discarded.
  - `fire` in that cycle is suppressed.
  - State and `gap_cnt` continue unchanged, so spacing is still honoured after `clear`.
- `reset` has priority over `clear`.
- Reset values: `out`=0, `pending`=0, `overflow`=0, state=IDLE, `gap_cnt`=0, `busy`=0.
- Reset mid-SPACE abandons the gap. Events pending at reset are lost and not flagged.
- `overflow` clears only on `reset` or `clear`.

## Timing
- Latency, idle block with empty queue: `in` high at cycle N → `pending`=1 at N+1 → `out` high at N+2.
- Spacing: consecutive `out` rising edges are exactly GAP cycles apart while `pending` stays non-zero. They are never closer than GAP.
- Throughput: one event per GAP cycles sustained. A burst of k≤capacity events drains in (k−1)·GAP+1 cycles of `out` activity.
- `pending` and `overflow` are registered and update the cycle after the causing input.
- `busy` is combinational from registers (no input-to-output paths).
- Downstream requirement: GAP ≥ 3×(slow clock period / fast clock period) + 2 cycles of margin when feeding a cross-domain pulse synchronizer. The instantiating module sets GAP accordingly.
- Counter arithmetic:
  - `pending` is unsigned CNT_W bits and never wraps in either direction.
  - `gap_cnt` width is $clog2(GAP−1), with a minimum of 1.

## Structure
- Package `pulse_pacer_pkg`:
  - state enum `pacer_state_t` {IDLE, SPACE};
  - function `pacer_gap_min(fast_ratio)` for computing GAP at instantiation sites.
- One sub-module is natural: `sat_updown_cnt`, a saturating up/down counter with `inc`, `dec`, `clr`, `count` and `sat_hit` outputs.
- Gap counter and FSM are inline in `pulse_pacer`.

## Test plan
- **Single event**: GAP=8, one `in` pulse at cycle 10 → `out` at cycle 12 only; `pending` 1 at cycle 11, 0 at cycle 13; `busy` low from cycle 20.
- **Burst**: GAP=8, `in` high cycles 10–14 (5 events) → `out` at 12, 20, 28, 36, 44; `pending` peaks at 4 (cycle 13 onward: +1 per cycle, −1 at 12); `overflow` stays 0.
- **Saturation**: CNT_W=2, GAP=8, `in` high cycles 0–5 → `pending` reaches 3 and holds; `overflow`=1 from the first lost event; exactly 4 `out` pulses total (1 emitted during the burst + 3 queued).
- **Simultaneous inc/dec at full**: CNT_W=2, `pending`=3, `in` high in the cycle `fire` asserts → `pending` stays 3, `overflow` stays 0.
- **Clear mid-gap**: `out` at cycle 20, 3 pending, `clear` at cycle 22 together with `in` → `pending`=0 and `overflow`=0 at cycle 23; no further `out`; a new `in` at cycle 23 gives `out` no earlier than cycle 28.
- **Reset mid-SPACE**: `reset` at cycle 25 with `pending`=2 → all outputs 0 at cycle 26; `in` at cycle 30 gives `out` at cycle 32.
